// File: rtl/mem_access_unit_pkg.sv
// mips_mem_pkg: opcodes, fault codes and enums shared by the MEM-stage load/store unit
package mips_mem_pkg;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory bus between the load/store unit and memory
interface mem_access_unit_if #(parameter int ADDR_WIDTH = 32);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_op_decode.sv
// mem_op_decode: classifies a MIPS primary opcode into load/store, access size and extension
module mem_op_decode
    import mips_mem_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_load,
    output logic       is_store,
    output logic       is_mem,
    output size_t      size,
    output logic       sign_ext
);
    always_comb begin
        is_load  = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_store = opcode inside {OP_SB, OP_SH, OP_SW};
        is_mem   = is_load | is_store;
        size     = (opcode inside {OP_LB, OP_LBU, OP_SB}) ? SZ_BYTE :
                   (opcode inside {OP_LH, OP_LHU, OP_SH}) ? SZ_HALF : SZ_WORD;
        sign_ext = opcode inside {OP_LB, OP_LH};
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller with alignment check, wait states and timeout
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit BIG_ENDIAN     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [5:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_mem,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  fault,
    output logic [1:0]            fault_code,
    mem_access_unit_if.master     bus
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    size_t                 size, size_q, size_d;
    logic                  sign_ext, sext_q, sext_d;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [1:0]            code_q, code_d;
    logic [1:0]            lane;
    logic                  misaligned, timeout;
    logic [31:0]           byte_sh, half_sh, ext;

    mem_op_decode u_dec (
        .opcode  (opcode),
        .is_load (is_load),
        .is_store(is_store),
        .is_mem  (is_mem),
        .size    (size),
        .sign_ext(sign_ext)
    );

    assign done          = state_q == S_DONE;
    assign stall         = op_valid & is_mem & ~done;
    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign fault_code    = code_q;
    assign bus.mem_req   = state_q == S_REQ;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

    always_comb begin
        // In big-endian mode byte k of the word sits in lane 3-k, i.e. the inverted low address bits
        lane       = BIG_ENDIAN ? ~addr[1:0] : addr[1:0];
        misaligned = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
        timeout    = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        byte_sh    = bus.mem_rdata >> {lane_q, 3'b000};
        half_sh    = bus.mem_rdata >> {lane_q[1], 4'b0000};
        ext        = size_q == SZ_BYTE ? {{24{sext_q & byte_sh[7]}}, byte_sh[7:0]} :
                     size_q == SZ_HALF ? {{16{sext_q & half_sh[15]}}, half_sh[15:0]} : bus.mem_rdata;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sext_d  = sext_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: if (op_valid && is_mem) begin
                addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                we_d    = is_store;
                be_d    = is_load ? 4'hF : size == SZ_BYTE ? 4'b0001 << lane :
                          size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'hF;
                wdata_d = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
                lane_d  = lane;
                size_d  = size;
                sext_d  = sign_ext;
                cnt_d   = '0;
                fault_d = misaligned;
                code_d  = misaligned ? FC_MISALIGN : FC_NONE;
                state_d = misaligned ? S_DONE : S_REQ;
            end
            S_REQ: if (bus.mem_ack) begin
                rdata_d = we_q ? rdata_q : ext;
                state_d = S_DONE;
            end else if (timeout) begin
                fault_d = 1'b1;
                code_d  = FC_TIMEOUT;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= '0;
            lane_q  <= 2'b00;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end
endmodule
